// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU datapath blocks.
//
// Holds the ALU operation encodings, the bit positions of the {N,Z,C,V}
// flag nibble, the state encoding of the sequential multiplier, and a
// small helper that assembles a flag nibble from its individual bits.
// No ports: this file is a package only.
package mcu_pkg;

   // ALU operation encodings; MUL is serviced by mul_seq instead of a
   // single-cycle macro.
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_ORR   = 3'b011;
   localparam logic [2:0] ALU_BPASS = 3'b100;
   localparam logic [2:0] ALU_MUL   = 3'b111;

   // Bit positions inside the 4-bit {N,Z,C,V} flag nibble.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Sequential multiplier controller states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mulState_t;

   // Builds a flag nibble; keeps callers independent of the bit ordering.
   function automatic logic [3:0] makeFlags(input logic n, input logic z,
                                            input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiplier serving ALU MUL requests.
//
// The controller pulses start while ready is high; operands are sampled in
// that cycle. The block multiplies operand magnitudes one multiplier bit per
// cycle, applies the sign at the end and presents the full 2*WIDTH product
// together with ALU-style flags, pulsing done for one cycle.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       request pulse, accepted only while ready=1
//   is_signed   1 = two's-complement operands, 0 = unsigned
//   a, b        multiplicand and multiplier (WIDTH bits)
//   ready       high while idle
//   done        one-cycle pulse when the product is valid
//   product_lo  low half of the product (ALU result for MUL)
//   product_hi  high half of the product
//   flags       {N,Z,C,V}; C and V are always 0
module mul_seq
   import mcu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] product_lo,
   output logic [WIDTH-1:0] product_hi,
   output logic [3:0]       flags
);

   localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   mulState_t            r_state;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_negRes;
   logic                 r_ready;
   logic                 r_done;
   logic [WIDTH-1:0]     r_productLo;
   logic [WIDTH-1:0]     r_productHi;
   logic [3:0]           r_flags;

   logic [WIDTH-1:0]     w_absA;
   logic [WIDTH-1:0]     w_absB;
   logic                 w_negRes;
   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_accNext;
   logic [WIDTH-1:0]     w_mplierNext;
   logic [2*WIDTH-1:0]   w_final;
   logic                 w_lastIter;

   // Operand magnitudes at acceptance. The most negative value negates to
   // itself, which read as unsigned is exactly its magnitude, so it needs no
   // special handling.
   assign w_absA   = (is_signed && a[WIDTH-1]) ? ('0 - a) : a;
   assign w_absB   = (is_signed && b[WIDTH-1]) ? ('0 - b) : b;
   assign w_negRes = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

   // One shift-add step: the accumulator value after this RUN cycle, and the
   // signed product that would be published if this is the final step.
   assign w_addend     = r_mplier[0] ? r_mcand : '0;
   assign w_accNext    = r_acc + w_addend;
   assign w_mplierNext = r_mplier >> 1;
   assign w_final      = r_negRes ? ('0 - w_accNext) : w_accNext;

   // RUN ends after the WIDTH-th step, or earlier when no multiplier bits
   // remain and early exit is enabled.
   assign w_lastIter = (r_cnt == CNT_LAST) ||
                       (EARLY_EXIT && (w_mplierNext == '0));

   // Controller and datapath. All outputs are registered here: ready drops
   // on acceptance and returns when leaving DONE, done is set only on the
   // RUN->DONE edge, and the product/flags registers are written only then
   // so they hold across later requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_negRes    <= 1'b0;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
         r_productLo <= '0;
         r_productHi <= '0;
         r_flags     <= makeFlags(1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_absA};
                  r_mplier <= w_absB;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_negRes <= w_negRes;
                  r_ready  <= 1'b0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_acc    <= w_accNext;
               r_mcand  <= r_mcand << 1;
               r_mplier <= w_mplierNext;
               r_cnt    <= r_cnt + CW'(1);
               if (w_lastIter) begin
                  r_productLo <= w_final[WIDTH-1:0];
                  r_productHi <= w_final[2*WIDTH-1:WIDTH];
                  r_flags     <= makeFlags(w_final[WIDTH-1],
                                           (w_final[WIDTH-1:0] == '0),
                                           1'b0, 1'b0);
                  r_done      <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ready      = r_ready;
   assign done       = r_done;
   assign product_lo = r_productLo;
   assign product_hi = r_productHi;
   assign flags      = r_flags;

endmodule

// File: tb/tb_mul_seq.sv
// Directed testbench for mul_seq.
//
// Two instances share the operand inputs: dut0 runs the full WIDTH
// iterations, dut1 has early exit enabled. Each has its own start pulse.
// Cycle numbering: cycle 0 is the cycle in which start is high; cycle n is
// observed 1 time unit after the n-th following rising edge.
module tb_mul_seq;

   logic        clock;
   logic        reset;
   logic        start0;
   logic        start1;
   logic        isSigned;
   logic [31:0] opA;
   logic [31:0] opB;

   logic        ready0, done0, ready1, done1;
   logic [31:0] lo0, hi0, lo1, hi1;
   logic [3:0]  flags0, flags1;

   int vecCount  = 0;
   int missCount = 0;

   int          doneCycle;
   int          doneCount;
   logic [31:0] capLo;
   logic [31:0] capHi;
   logic [3:0]  capFlags;
   logic        readyAfter;
   logic        readyFirst;

   mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clock), .reset(reset), .start(start0), .is_signed(isSigned),
      .a(opA), .b(opB), .ready(ready0), .done(done0),
      .product_lo(lo0), .product_hi(hi0), .flags(flags0)
   );

   mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clock), .reset(reset), .start(start1), .is_signed(isSigned),
      .a(opA), .b(opB), .ready(ready1), .done(done1),
      .product_lo(lo1), .product_hi(hi1), .flags(flags1)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drives a start pulse in cycle 0 and returns positioned in cycle 1.
   task automatic applyStimulus(input bit sel, input logic sgn,
                                input logic [31:0] av, input logic [31:0] bv);
      @(negedge clock);
      isSigned = sgn;
      opA      = av;
      opB      = bv;
      if (sel) start1 = 1'b1;
      else     start0 = 1'b1;
      @(posedge clock);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Observes cycles 1..limit, recording the first done cycle, the number of
   // done pulses, the outputs seen with done, and ready around the operation.
   task automatic observeRun(input bit sel, input int limit);
      doneCycle  = -1;
      doneCount  = 0;
      readyAfter = 1'b0;
      readyFirst = 1'b1;
      capLo      = '0;
      capHi      = '0;
      capFlags   = '0;
      for (int c = 1; c <= limit; c++) begin
         if (c == 1) readyFirst = sel ? ready1 : ready0;
         if (doneCycle >= 0 && c == doneCycle + 1) readyAfter = sel ? ready1 : ready0;
         if (sel ? done1 : done0) begin
            doneCount++;
            if (doneCycle < 0) begin
               doneCycle = c;
               capLo     = sel ? lo1 : lo0;
               capHi     = sel ? hi1 : hi0;
               capFlags  = sel ? flags1 : flags0;
            end
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      vecCount++;
      if (ready0 !== 1'b1) begin missCount++; $display("[TB] FAIL reset_ready: got %b expected 1", ready0); end
      vecCount++;
      if (done0 !== 1'b0) begin missCount++; $display("[TB] FAIL reset_done: got %b expected 0", done0); end
      vecCount++;
      if ({hi0, lo0} !== 64'h0) begin missCount++; $display("[TB] FAIL reset_product: got %h expected 0", {hi0, lo0}); end
      vecCount++;
      if (flags0 !== 4'b0100) begin missCount++; $display("[TB] FAIL reset_flags: got %b expected 0100", flags0); end
      vecCount++;
      if (ready1 !== 1'b1) begin missCount++; $display("[TB] FAIL reset_ready_ee: got %b expected 1", ready1); end
   endtask

   task automatic test_unsigned_small();
      applyStimulus(1'b0, 1'b0, 32'd3, 32'd5);
      observeRun(1'b0, 40);
      vecCount++;
      if (readyFirst !== 1'b0) begin missCount++; $display("[TB] FAIL u3x5_busy_ready: got %b expected 0", readyFirst); end
      vecCount++;
      if (doneCycle !== 33) begin missCount++; $display("[TB] FAIL u3x5_latency: got %0d expected 33", doneCycle); end
      vecCount++;
      if (doneCount !== 1) begin missCount++; $display("[TB] FAIL u3x5_done_pulses: got %0d expected 1", doneCount); end
      vecCount++;
      if (capLo !== 32'h0000000F || capHi !== 32'h0) begin missCount++; $display("[TB] FAIL u3x5_product: got %h_%h expected 00000000_0000000f", capHi, capLo); end
      vecCount++;
      if (capFlags !== 4'b0000) begin missCount++; $display("[TB] FAIL u3x5_flags: got %b expected 0000", capFlags); end
      vecCount++;
      if (readyAfter !== 1'b1) begin missCount++; $display("[TB] FAIL u3x5_ready_after: got %b expected 1", readyAfter); end
   endtask

   task automatic test_signed();
      applyStimulus(1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000003);
      observeRun(1'b0, 40);
      vecCount++;
      if (capHi !== 32'hFFFFFFFF || capLo !== 32'hFFFFFFFA) begin missCount++; $display("[TB] FAIL s_m2x3_product: got %h_%h expected ffffffff_fffffffa", capHi, capLo); end
      vecCount++;
      if (capFlags !== 4'b1000) begin missCount++; $display("[TB] FAIL s_m2x3_flags: got %b expected 1000", capFlags); end

      applyStimulus(1'b0, 1'b1, 32'h80000000, 32'h80000000);
      observeRun(1'b0, 40);
      vecCount++;
      if (capHi !== 32'h40000000 || capLo !== 32'h0) begin missCount++; $display("[TB] FAIL s_min_sq_product: got %h_%h expected 40000000_00000000", capHi, capLo); end
      vecCount++;
      if (capFlags !== 4'b0100) begin missCount++; $display("[TB] FAIL s_min_sq_flags: got %b expected 0100", capFlags); end
   endtask

   task automatic test_unsigned_max();
      applyStimulus(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      observeRun(1'b0, 40);
      vecCount++;
      if (capHi !== 32'hFFFFFFFE || capLo !== 32'h00000001) begin missCount++; $display("[TB] FAIL u_max_product: got %h_%h expected fffffffe_00000001", capHi, capLo); end
      vecCount++;
      if (capFlags !== 4'b0000) begin missCount++; $display("[TB] FAIL u_max_flags: got %b expected 0000", capFlags); end
      vecCount++;
      if (lo0 !== 32'h00000001) begin missCount++; $display("[TB] FAIL u_max_hold: got %h expected 00000001", lo0); end
   endtask

   task automatic test_early_exit();
      applyStimulus(1'b1, 1'b0, 32'd12345, 32'd0);
      observeRun(1'b1, 40);
      vecCount++;
      if (doneCycle !== 2) begin missCount++; $display("[TB] FAIL ee_b0_latency: got %0d expected 2", doneCycle); end
      vecCount++;
      if ({capHi, capLo} !== 64'h0) begin missCount++; $display("[TB] FAIL ee_b0_product: got %h expected 0", {capHi, capLo}); end
      vecCount++;
      if (capFlags !== 4'b0100) begin missCount++; $display("[TB] FAIL ee_b0_flags: got %b expected 0100", capFlags); end

      applyStimulus(1'b1, 1'b0, 32'd7, 32'h00000100);
      observeRun(1'b1, 40);
      vecCount++;
      if (doneCycle !== 10) begin missCount++; $display("[TB] FAIL ee_7x256_latency: got %0d expected 10", doneCycle); end
      vecCount++;
      if (capLo !== 32'h00000700 || capHi !== 32'h0) begin missCount++; $display("[TB] FAIL ee_7x256_product: got %h_%h expected 00000000_00000700", capHi, capLo); end
      vecCount++;
      if (doneCount !== 1) begin missCount++; $display("[TB] FAIL ee_7x256_pulses: got %0d expected 1", doneCount); end
   endtask

   task automatic test_busy_ignore();
      int          seenCycle;
      int          seenCount;
      logic [31:0] seenLo;
      seenCycle = -1;
      seenCount = 0;
      seenLo    = '0;
      applyStimulus(1'b0, 1'b0, 32'd3, 32'd5);
      for (int c = 1; c <= 45; c++) begin
         if (done0) begin
            seenCount++;
            if (seenCycle < 0) begin
               seenCycle = c;
               seenLo    = lo0;
            end
         end
         if (c == 5) begin
            @(negedge clock);
            opA    = 32'd9;
            opB    = 32'd9;
            start0 = 1'b1;
            @(posedge clock);
            #1;
            start0 = 1'b0;
         end else begin
            @(posedge clock);
            #1;
         end
      end
      vecCount++;
      if (seenCount !== 1) begin missCount++; $display("[TB] FAIL busy_done_pulses: got %0d expected 1", seenCount); end
      vecCount++;
      if (seenCycle !== 33) begin missCount++; $display("[TB] FAIL busy_latency: got %0d expected 33", seenCycle); end
      vecCount++;
      if (seenLo !== 32'd15) begin missCount++; $display("[TB] FAIL busy_product: got %0d expected 15", seenLo); end
   endtask

   task automatic test_reset_abort();
      int abortDones;
      abortDones = 0;
      applyStimulus(1'b0, 1'b0, 32'd3, 32'd5);
      for (int c = 1; c < 10; c++) begin
         @(posedge clock);
         #1;
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      vecCount++;
      if (ready0 !== 1'b1) begin missCount++; $display("[TB] FAIL abort_ready: got %b expected 1", ready0); end
      vecCount++;
      if ({hi0, lo0} !== 64'h0) begin missCount++; $display("[TB] FAIL abort_product: got %h expected 0", {hi0, lo0}); end
      vecCount++;
      if (flags0 !== 4'b0100) begin missCount++; $display("[TB] FAIL abort_flags: got %b expected 0100", flags0); end
      @(negedge clock);
      reset = 1'b0;
      for (int c = 11; c <= 40; c++) begin
         if (done0) abortDones++;
         @(posedge clock);
         #1;
      end
      vecCount++;
      if (abortDones !== 0) begin missCount++; $display("[TB] FAIL abort_no_done: got %0d expected 0", abortDones); end

      applyStimulus(1'b0, 1'b0, 32'd2, 32'd2);
      observeRun(1'b0, 40);
      vecCount++;
      if (doneCycle !== 33) begin missCount++; $display("[TB] FAIL fresh_latency: got %0d expected 33", doneCycle); end
      vecCount++;
      if (capLo !== 32'd4 || capHi !== 32'd0) begin missCount++; $display("[TB] FAIL fresh_product: got %h_%h expected 00000000_00000004", capHi, capLo); end
   endtask

   // Test sequence.
   initial begin
      reset    = 1'b1;
      start0   = 1'b0;
      start1   = 1'b0;
      isSigned = 1'b0;
      opA      = '0;
      opB      = '0;
      $display("[TB] mul_seq directed tests starting");
      test_reset();
      test_unsigned_small();
      test_signed();
      test_unsigned_max();
      test_early_exit();
      test_busy_ignore();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
